move_sequencer: RTL

Turn controller between two move sources (X, O) and the `GameState` board block. Only the player whose turn it is may move. It pre-checks the requested square, issues a one-cycle move command to `GameState`, and reads back `GameStatus`. It then acks/nacks the requester, passes the turn, or latches the game result. It also sequences new-game clears and optional per-turn timeouts.

---
 rtl/move_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Turn controller between the X and O move sources and the GameState board block.
// It pre-checks squares, strobes moves, reads back GameStatus, and sequences clears and timeouts.
module move_sequencer #(
    parameter bit FIRST_PLAYER = 1'b1,
    parameter int CLR_CYCLES   = 2,
    parameter int MOVE_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       x_req,
    input  logic [3:0] x_pos,
    input  logic       o_req,
    input  logic [3:0] o_pos,
    input  logic [8:0] X_state,
    input  logic [8:0] O_state,
    input  logic [2:0] GameStatus,
    output logic       gs_rst,
    output logic       move,
    output logic       player,
    output logic [3:0] nextMove,
    output logic       turn,
    output logic       x_ack,
    output logic       x_nack,
    output logic       o_ack,
    output logic       o_nack,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       timeout
);
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int TW = (MOVE_TIMEOUT > 0) ? $clog2(MOVE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = (MOVE_TIMEOUT > 0) ? TW'(MOVE_TIMEOUT - 1) : '0;
    localparam bit TMO_EN = (MOVE_TIMEOUT > 0);

    typedef enum logic [2:0] {CLEAR, WAIT_REQ, ISSUE, SETTLE, CHECK, OVER} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   clr_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            chk_play_q, chk_end_q;
    logic            cur_req, pos_ok, accept, reject, tmo_hit, clr_done, st_play, st_end;
    logic [3:0]      cur_pos;
    logic [15:0]     occ16;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TMO_LAST) ? v : v + 1'b1;
    endfunction

    // Squares 9..15 read as occupied so an out-of-range position is rejected by the same test.
    assign cur_req  = turn ? x_req : o_req;
    assign cur_pos  = turn ? x_pos : o_pos;
    assign occ16    = {7'h7f, X_state | O_state};
    assign pos_ok   = !occ16[cur_pos];
    assign accept   = (state == WAIT_REQ) && cur_req && pos_ok;
    assign reject   = (state == WAIT_REQ) && cur_req && !pos_ok;
    assign tmo_hit  = TMO_EN && (state == WAIT_REQ) && !accept && (tmo_cnt == TMO_LAST);
    assign clr_done = (clr_cnt == CLR_LAST);
    assign st_play  = (GameStatus == 3'b000);
    assign st_end   = !GameStatus[2] && (GameStatus[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = CLEAR;
        end else begin
            case (state)
                CLEAR:    if (clr_done) state_nxt = WAIT_REQ;
                WAIT_REQ: if (accept) state_nxt = ISSUE;
                ISSUE:    state_nxt = SETTLE;
                SETTLE:   state_nxt = CHECK;
                CHECK:    state_nxt = chk_end_q ? OVER : WAIT_REQ;
                OVER:     state_nxt = OVER;
                default:  state_nxt = CLEAR;
            endcase
        end
    end

    // GameStatus is sampled on the edge leaving SETTLE so the response is visible during CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gs_rst     <= 1'b1;
            move       <= 1'b0;
            player     <= FIRST_PLAYER;
            nextMove   <= 4'd0;
            turn       <= FIRST_PLAYER;
            x_ack      <= 1'b0;
            x_nack     <= 1'b0;
            o_ack      <= 1'b0;
            o_nack     <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            timeout    <= 1'b0;
            clr_cnt    <= '0;
            tmo_cnt    <= '0;
            chk_play_q <= 1'b0;
            chk_end_q  <= 1'b0;
        end else begin
            move    <= 1'b0;
            x_ack   <= 1'b0;
            x_nack  <= 1'b0;
            o_ack   <= 1'b0;
            o_nack  <= 1'b0;
            timeout <= 1'b0;
            if (new_game) begin
                gs_rst    <= 1'b1;
                clr_cnt   <= '0;
                tmo_cnt   <= '0;
                turn      <= FIRST_PLAYER;
                game_over <= 1'b0;
                winner    <= 2'b00;
            end else begin
                case (state)
                    CLEAR: begin
                        turn      <= FIRST_PLAYER;
                        game_over <= 1'b0;
                        winner    <= 2'b00;
                        tmo_cnt   <= '0;
                        if (clr_done) begin
                            gs_rst  <= 1'b0;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    WAIT_REQ: begin
                        if (accept) begin
                            move     <= 1'b1;
                            player   <= turn;
                            nextMove <= cur_pos;
                            tmo_cnt  <= '0;
                        end else begin
                            if (reject) begin
                                x_nack <= turn;
                                o_nack <= !turn;
                            end
                            if (tmo_hit) begin
                                timeout <= 1'b1;
                                turn    <= !turn;
                                tmo_cnt <= '0;
                            end else begin
                                tmo_cnt <= sat_inc(tmo_cnt);
                            end
                        end
                    end
                    SETTLE: begin
                        chk_play_q <= st_play;
                        chk_end_q  <= st_end;
                        if (st_play || st_end) begin
                            x_ack <= turn;
                            o_ack <= !turn;
                        end else begin
                            x_nack <= turn;
                            o_nack <= !turn;
                        end
                        if (st_end) begin
                            winner    <= GameStatus[1:0];
                            game_over <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (chk_play_q) begin
                            turn    <= !turn;
                            tmo_cnt <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
